seq_alu: RTL and testbench

Parametrised, handshaked execute unit for the core: performs the base integer ALU operations in one registered cycle and the RV32M multiply/divide operations iteratively over XLEN cycles. It sits between decode/operand-fetch and writeback. It accepts one operation at a time over a valid/ready input and holds the result on a valid/ready output until writeback takes it.

---
 rtl/alu_pkg.sv | 54 +++++
 rtl/seq_alu_mdu.sv | 103 ++++++++++
 rtl/seq_alu.sv | 137 +++++++++++++
 tb/tb_seq_alu.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Op encoding, f3 codes, FSM states and XLEN-sized constants for the execute unit.
// Constants are built as 64-bit words and narrowed at the use site, so XLEN may not exceed 64.
package alu_pkg;

    typedef struct packed {
        logic       m;
        logic       alt;
        logic       rsvd;
        logic [2:0] f3;
    } op_t;

    localparam logic [2:0] F3_ADD    = 3'd0;
    localparam logic [2:0] F3_SLL    = 3'd1;
    localparam logic [2:0] F3_SLT    = 3'd2;
    localparam logic [2:0] F3_SLTU   = 3'd3;
    localparam logic [2:0] F3_XOR    = 3'd4;
    localparam logic [2:0] F3_SR     = 3'd5;
    localparam logic [2:0] F3_OR     = 3'd6;
    localparam logic [2:0] F3_AND    = 3'd7;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    localparam int MAX_XLEN = 64;

    function automatic logic [MAX_XLEN-1:0] all_ones(input int xlen);
        logic [MAX_XLEN-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_XLEN; i++) begin
            if (i < xlen) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [MAX_XLEN-1:0] min_signed(input int xlen);
        logic [MAX_XLEN-1:0] r;
        r = '0;
        r[xlen-1] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/seq_alu_mdu.sv
// Iterative RV32M datapath: shift-add multiply and restoring divide on magnitudes, sign fixup on the last step.
// Latency: done_o in the XLEN-th cycle after start_i; no backpressure, the caller samples result_o while done_o=1.
module mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic [2:0]      f3_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    logic [2*XLEN-1:0] acc_q, acc_d, step;
    logic [XLEN-1:0]   b_q, b_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              is_div_q, is_div_d;
    logic              sel_hi_q, sel_hi_d;
    logic              neg_q, neg_d;

    logic              signed_a, signed_b, neg_a, neg_b;
    logic [XLEN-1:0]   mag_a, mag_b, hi, lo;
    logic [XLEN:0]     mul_sum;
    logic              div_borrow, div_unused_msb;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   half;

    // acc holds {partial, multiplier} for multiply and {remainder, dividend/quotient} for divide
    assign hi = acc_q[2*XLEN-1:XLEN];
    assign lo = acc_q[XLEN-1:0];

    assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
    assign {div_borrow, div_unused_msb, div_diff} = {1'b0, hi, lo[XLEN-1]} - {2'b00, b_q};

    always_comb begin
        step = {mul_sum, lo[XLEN-1:1]};
        if (is_div_q) begin
            step = div_borrow ? {hi[XLEN-2:0], lo, 1'b0} : {div_diff, lo[XLEN-2:0], 1'b1};
        end
    end

    always_comb begin
        signed_a = f3_i[2] ? ~f3_i[0] : ((f3_i == F3_MULH) || (f3_i == F3_MULHSU));
        signed_b = f3_i[2] ? ~f3_i[0] : (f3_i == F3_MULH);
        neg_a    = signed_a & a_i[XLEN-1];
        neg_b    = signed_b & b_i[XLEN-1];
        mag_a    = neg_a ? -a_i : a_i;
        mag_b    = neg_b ? -b_i : b_i;
    end

    // Product is negated as a whole; quotient/remainder are negated after picking the half
    always_comb begin
        prod_fix = (~is_div_q & neg_q) ? -step : step;
        half     = sel_hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
        result_o = (is_div_q & neg_q) ? -half : half;
        done_o   = (cnt_q == CNT_W'(1));
    end

    always_comb begin
        acc_d    = acc_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sel_hi_d = sel_hi_q;
        neg_d    = neg_q;
        if (start_i) begin
            acc_d    = {{XLEN{1'b0}}, mag_a};
            b_d      = mag_b;
            cnt_d    = CNT_W'(XLEN);
            is_div_d = f3_i[2];
            sel_hi_d = f3_i[2] ? f3_i[1] : (f3_i != F3_MUL);
            neg_d    = (f3_i == F3_REM) ? neg_a : (neg_a ^ neg_b);
        end else if (cnt_q != '0) begin
            acc_d = step;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q    <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sel_hi_q <= 1'b0;
            neg_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sel_hi_q <= sel_hi_d;
            neg_q    <= neg_d;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked execute unit: base ALU ops and division special cases in one cycle, other M ops via mdu_iter.
// Latency 1 or XLEN+1 cycles; result is held until out_ready, and a new op is taken in the retire cycle.
module seq_alu
    import alu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [5:0]      in_op,
    input  logic [XLEN-1:0] in_a,
    input  logic [XLEN-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic            out_err
);

    localparam int              SH_W  = $clog2(XLEN);
    localparam logic [XLEN-1:0] ONES  = XLEN'(all_ones(XLEN));
    localparam logic [XLEN-1:0] MIN_S = XLEN'(min_signed(XLEN));

    state_t          state_q, state_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            err_q, err_d;

    op_t             op;
    logic            unused_rsvd;
    logic            accept, mdu_start, mdu_done;
    logic [XLEN-1:0] mdu_result;
    logic            is_unknown, is_div, b_zero, div_ovf, is_iter;
    logic [SH_W-1:0] shamt;
    logic [XLEN-1:0] sra_res, base_res, imm_res;

    assign op          = op_t'(in_op);
    assign unused_rsvd = op.rsvd;
    assign shamt       = in_b[SH_W-1:0];
    assign sra_res     = $signed(in_a) >>> shamt;

    always_comb begin
        base_res = '0;
        case (op.f3)
            F3_ADD:  base_res = op.alt ? (in_a - in_b) : (in_a + in_b);
            F3_SLL:  base_res = in_a << shamt;
            F3_SLT:  base_res = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
            F3_SLTU: base_res = {{(XLEN-1){1'b0}}, (in_a < in_b)};
            F3_XOR:  base_res = in_a ^ in_b;
            F3_SR:   base_res = op.alt ? sra_res : (in_a >> shamt);
            F3_OR:   base_res = in_a | in_b;
            F3_AND:  base_res = in_a & in_b;
            default: base_res = '0;
        endcase
    end

    // Divide-by-zero and signed overflow never enter the iterative datapath
    always_comb begin
        is_unknown = op.m & op.alt;
        is_div     = op.m & ~op.alt & op.f3[2];
        b_zero     = (in_b == '0);
        div_ovf    = ~op.f3[0] & (in_a == MIN_S) & (in_b == ONES);
        is_iter    = op.m & ~op.alt & ~(is_div & (b_zero | div_ovf));
        imm_res    = base_res;
        if (is_unknown) begin
            imm_res = '0;
        end else if (is_div && b_zero) begin
            imm_res = op.f3[1] ? in_a : ONES;
        end else if (is_div && div_ovf) begin
            imm_res = op.f3[1] ? '0 : in_a;
        end
    end

    assign in_ready  = ~reset & ((state_q == IDLE) | ((state_q == DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign out_data  = data_q;
    assign out_err   = err_q;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        err_d     = err_q;
        mdu_start = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE && out_ready) state_d = IDLE;
                if (accept) begin
                    if (is_iter) begin
                        state_d   = BUSY;
                        mdu_start = 1'b1;
                    end else begin
                        state_d = DONE;
                        data_d  = imm_res;
                        err_d   = is_unknown;
                    end
                end
            end
            BUSY: begin
                if (mdu_done) begin
                    state_d = DONE;
                    data_d  = mdu_result;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    mdu_iter #(
        .XLEN  (XLEN),
        .CNT_W (CNT_W)
    ) u_mdu (
        .clk      (clk),
        .reset    (reset),
        .start_i  (mdu_start),
        .f3_i     (op.f3),
        .a_i      (in_a),
        .b_i      (in_b),
        .done_o   (mdu_done),
        .result_o (mdu_result)
    );

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu at XLEN=32, plus a directed XLEN=8 instance.
module tb_seq_alu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready, out_err;
    logic [5:0]  in_op;
    logic [31:0] in_a, in_b, out_data;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, out_err8;
    logic [5:0]  in_op8;
    logic [7:0]  in_a8, in_b8, out_data8;

    seq_alu #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err)
    );

    seq_alu #(.XLEN(8)) dut8 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_op(in_op8), .in_a(in_a8), .in_b(in_b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8), .out_err(out_err8)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] d;
        logic        e;
        int          due;
        string       name;
    } exp_t;
    exp_t sb_q[$];

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per retired result and checks data, err and first-valid cycle
    initial begin
        exp_t e;
        bit   prev_vld;
        bit   prev_ret;
        int   vstart;
        prev_vld = 0;
        prev_ret = 0;
        vstart   = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_vld = 0;
                prev_ret = 0;
            end else begin
                if (out_valid && (!prev_vld || prev_ret)) vstart = cyc;
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        check32("spurious_result", 32'(out_valid), 32'd0);
                    end else begin
                        e = sb_q.pop_front();
                        check32({e.name, "_data"}, out_data, e.d);
                        check32({e.name, "_err"}, 32'(out_err), 32'(e.e));
                        check32({e.name, "_lat"}, vstart, e.due);
                    end
                end
                prev_vld = out_valid;
                prev_ret = out_valid && out_ready;
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge
    task automatic issue(input string name, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_d, input logic exp_e,
                         input int lat, input bit push, output int acc_cyc);
        int   waited;
        exp_t e;
        waited  = 0;
        acc_cyc = -1;
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        while (acc_cyc < 0) begin
            @(negedge clk);
            if (in_ready) begin
                acc_cyc = cyc;
            end else begin
                waited++;
                if (waited > 200) begin
                    check32({name, "_accept_timeout"}, 32'd1, 32'd0);
                    break;
                end
            end
        end
        if (push && acc_cyc >= 0) begin
            e.d    = exp_d;
            e.e    = exp_e;
            e.due  = acc_cyc + lat;
            e.name = name;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_op    = 6'b110000;
        in_a     = 32'hDEADBEEF;
        in_b     = 32'h0000_0001;
    endtask

    task automatic op32(input string name, input logic [5:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_d, input logic exp_e, input int lat);
        int c;
        issue(name, op, a, b, exp_d, exp_e, lat, 1'b1, c);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check32("drain_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int  c, start, n, acc;
        bit  stale;
        reset = 1'b1;
        in_valid = 1'b0; in_op = '0; in_a = '0; in_b = '0; out_ready = 1'b1;
        in_valid8 = 1'b0; in_op8 = '0; in_a8 = '0; in_b8 = '0; out_ready8 = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rst_in_ready", 32'(in_ready), 32'd0);
        check32("rst_out_valid", 32'(out_valid), 32'd0);
        check32("rst_out_data", out_data, 32'd0);
        check32("rst_out_err", 32'(out_err), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check32("ready_after_reset", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Base ops back to back: each must be accepted and answered one cycle later
        op32("add",  6'b000000, 32'd7,          32'hFFFFFFFD, 32'd4,          1'b0, 1);
        op32("sub",  6'b010000, 32'd5,          32'd9,        32'hFFFFFFFC,   1'b0, 1);
        op32("sra",  6'b010101, 32'h80000000,   32'd4,        32'hF8000000,   1'b0, 1);
        op32("srl",  6'b000101, 32'h80000000,   32'd4,        32'h08000000,   1'b0, 1);
        op32("sll",  6'b000001, 32'd1,          32'd35,       32'd8,          1'b0, 1);
        op32("slt",  6'b000010, 32'hFFFFFFFF,   32'd1,        32'd1,          1'b0, 1);
        op32("sltu", 6'b000011, 32'hFFFFFFFF,   32'd1,        32'd0,          1'b0, 1);
        op32("xor",  6'b000100, 32'h0000F0F0,   32'h0000FF00, 32'h00000FF0,   1'b0, 1);
        op32("or",   6'b000110, 32'h0000F0F0,   32'h0000FF00, 32'h0000FFF0,   1'b0, 1);
        op32("and",  6'b000111, 32'h0000F0F0,   32'h0000FF00, 32'h0000F000,   1'b0, 1);
        op32("unk",  6'b110000, 32'd3,          32'd4,        32'd0,          1'b1, 1);
        drain();

        // M group: iterative ops at N+33, special divides at N+1
        op32("mulh",   6'b100001, 32'h80000000, 32'h80000000, 32'h40000000, 1'b0, 33);
        op32("mulhu",  6'b100011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 33);
        op32("mulhsu", 6'b100010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 33);
        op32("mul",    6'b100000, 32'd6,        32'hFFFFFFF9, 32'hFFFFFFD6, 1'b0, 33);
        op32("div",    6'b100100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 33);
        op32("rem",    6'b100110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 33);
        op32("divu",   6'b100101, 32'd100,      32'd7,        32'd14,       1'b0, 33);
        op32("remu",   6'b100111, 32'd100,      32'd7,        32'd2,        1'b0, 33);
        op32("divu0",  6'b100101, 32'd7,        32'd0,        32'hFFFFFFFF, 1'b0, 1);
        op32("remu0",  6'b100111, 32'd7,        32'd0,        32'd7,        1'b0, 1);
        op32("divovf", 6'b100100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1);
        op32("removf", 6'b100110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1'b0, 1);
        drain();

        // Backpressure: result held for 5 cycles, then retire and accept in the same cycle
        out_ready = 1'b0;
        op32("mul_bp", 6'b100000, 32'd3, 32'd5, 32'd15, 1'b0, 33);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check32("bp_data_stable", out_data, 32'd15);
            check32("bp_valid_held", 32'(out_valid), 32'd1);
            check32("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        start = cyc;
        issue("add_bp", 6'b000000, 32'd1, 32'd2, 32'd3, 1'b0, 1, 1'b1, acc);
        check32("bp_same_cycle_accept", acc, start);
        drain();

        // Reset in the 10th BUSY cycle of a divu: no result may ever appear
        issue("divu_abort", 6'b100101, 32'd1000, 32'd3, 32'd0, 1'b0, 0, 1'b0, c);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check32("abort_ready_in_reset", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check32("abort_out_valid", 32'(out_valid), 32'd0);
        check32("abort_in_ready", 32'(in_ready), 32'd1);
        stale = 0;
        repeat (45) begin
            @(negedge clk);
            if (out_valid) stale = 1;
        end
        check32("abort_no_stale", 32'(stale), 32'd0);

        // XLEN=8 instance
        @(posedge clk);
        #1;
        in_valid8 = 1'b1; in_op8 = 6'b100000; in_a8 = 8'h7F; in_b8 = 8'h7F;
        @(negedge clk);
        check32("x8_mul_ready", 32'(in_ready8), 32'd1);
        acc = cyc;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0; in_a8 = 8'h00; in_b8 = 8'h00;
        n = 0;
        @(negedge clk);
        while (!out_valid8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check32("x8_mul_lat", cyc, acc + 9);
        check32("x8_mul_data", 32'(out_data8), 32'h01);
        check32("x8_mul_err", 32'(out_err8), 32'd0);
        @(posedge clk);
        #1;
        in_valid8 = 1'b1; in_op8 = 6'b110000; in_a8 = 8'h12; in_b8 = 8'h34;
        @(negedge clk);
        check32("x8_unk_ready", 32'(in_ready8), 32'd1);
        acc = cyc;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        @(negedge clk);
        check32("x8_unk_valid", 32'(out_valid8), 32'd1);
        check32("x8_unk_lat", cyc, acc + 1);
        check32("x8_unk_data", 32'(out_data8), 32'h00);
        check32("x8_unk_err", 32'(out_err8), 32'd1);
        @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
